pokey_serin_rx: RTL and testbench
=================================

Name: pokey_serin_rx

Overview:
Serial-input receiver for the POKEY serial port. It is the receive-side counterpart of the SEROUT load/shift chain. It deserialises an asynchronous 10-bit frame from SID: start bit 0, 8 data bits LSB first, stop bit 1. It presents the byte as SERIN, raises the serial-input-ready request, and flags framing and overrun errors. Bit timing comes from the channel 3/4 timer as half-bit ticks; the block asks for a timer restart on each start edge, as async mode requires.

Parameters:
DATA_BITS, 8, number of data bits per frame (shift register and counter width follow)
SYNC_STAGES, 2, SID synchroniser depth (valid range 2 to 3)

Ports:
clk  input  1  master clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
enp  input  1  slow-clock enable; no state other than reset changes when enp=0
bit_tick  input  1  half-bit-period pulse from the timer; counts only when enp=1
sid  input  1  raw serial data input, idle high
irq_ack  input  1  clears rx_full (IRQST serial-input-ready acknowledge)
err_clr  input  1  SKRES strobe; clears frame_err and overrun_err
serin  output  DATA_BITS  last received byte
rx_done  output  1  one-enp-cycle pulse when serin updates
rx_full  output  1  byte ready and not yet acknowledged (IRQ request)
frame_err  output  1  sticky: stop bit sampled as 0
overrun_err  output  1  sticky: byte completed while rx_full=1
busy  output  1  state is not IDLE
timer_restart  output  1  one-enp-cycle pulse on start-edge detection

Behaviour:
- Reset (rst_n=0, async): synchroniser stages and sid_prev=1, state=IDLE, shift register=0, serin=0, all outputs 0.
- Effective tick: tk = enp & bit_tick. All register updates are qualified by enp.
- sid_s is the output of the SYNC_STAGES flop chain, clocked on enp cycles. sid_prev holds the previous sid_s.
- IDLE:
  - Falling edge (sid_prev=1, sid_s=0) -> START.
  - timer_restart=1 for that enp cycle. phase=0, bitcnt=0.
  - A level-low line with no edge, e.g. a break after a frame, does not start a frame.
- START: on the first tk, sample sid_s.
  - 0 -> DATA, phase=0.
  - 1 -> IDLE (glitch reject; no flags change).
- DATA: each tk toggles phase.
  - On a tk with phase=1 (mid-bit), shift: shreg <= {sid_s, shreg[DATA_BITS-1:1]}, bitcnt++.
  - After the DATA_BITS-th sample -> STOP, phase=0.
- STOP: on a tk with phase=1, sample the stop bit. In the same enp cycle:
  - serin <= shreg; rx_done=1.
  - frame_err set if sid_s=0. The byte is still delivered.
  - overrun_err set if rx_full=1 and irq_ack=0. serin is still overwritten.
  - rx_full <= 1; state -> IDLE.
- Latency:
  - The start edge is detected SYNC_STAGES enp cycles after sid falls.
  - rx_done fires on the tk that samples the stop bit. That is 19 ticks after START entry: 1 start confirm, 16 data, 2 stop.
- Simultaneous events:
  - irq_ack with rx_done: set wins, rx_full=1. Overrun is evaluated against pre-ack rx_full with ack taken into account, so there is no overrun.
  - err_clr with an error set: set wins.
  - irq_ack alone: rx_full=0 next cycle.
- rst_n asserted mid-frame: immediate return to IDLE, partial byte discarded. After release, the first frame needs a fresh falling edge.
- tk while enp=0 is ignored. bit_tick held high for several enp cycles counts once per enp cycle.
- busy=1 in START, DATA and STOP.

Test Plan:
- Reset, then frame 0xA5 (SID sequence 0,1,0,1,0,0,1,0,1,1) at 16 enp cycles per half-bit -> serin=0xA5, rx_done single pulse, rx_full=1, frame_err=0, overrun_err=0, timer_restart pulsed exactly once.
- SID low for 1 half-bit only, then high -> START aborts to IDLE; serin unchanged, no rx_done, no flags.
- Frame 0x3C with stop bit 0 -> serin=0x3C, frame_err=1. Line then held low -> no new frame. err_clr -> frame_err=0.
- Two back-to-back frames 0x11 then 0x22, no irq_ack -> serin=0x22, overrun_err=1. Repeat with irq_ack in the same cycle as the second rx_done -> overrun_err=0, rx_full=1.
- rst_n low during data bit 4 of 0xFF -> busy=0 and serin=0 immediately. Next frame 0x81 is received correctly.
- bit_tick held continuously high with enp pulsing every 4 clk -> one tick per enp cycle; frame 0x5A decodes correctly.

Source files
------------

// File: rtl/pokey_serin_rx_if.sv
// Host-side bus of the POKEY serial-input receiver: SERIN data, IRQ request and error flags.
interface pokey_serin_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 irq_ack;
  logic                 err_clr;
  logic [DATA_BITS-1:0] serin;
  logic                 rx_done;
  logic                 rx_full;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;
  logic                 timer_restart;

  // Host / CPU side: acknowledges and clears, observes data and status.
  modport master (
    output irq_ack, err_clr,
    input  serin, rx_done, rx_full, frame_err, overrun_err, busy, timer_restart
  );

  // Receiver side.
  modport slave (
    input  irq_ack, err_clr,
    output serin, rx_done, rx_full, frame_err, overrun_err, busy, timer_restart
  );
endinterface

// File: rtl/pokey_serin_rx.sv
// POKEY serial-input receiver: deserialises start/8 data/stop frames from SID using
// half-bit ticks from the channel 3/4 timer, and reports SERIN, ready and error status.
module pokey_serin_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enp,
  input  logic              bit_tick,
  input  logic              sid,
  pokey_serin_rx_if.slave   host
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sid_prev_q;
  logic                   phase_q, phase_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   serin_q, serin_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rx_full_q, rx_full_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
  logic                   restart_q, restart_d;

  logic sid_s;
  logic tk;
  logic fall;
  logic stop_smp;

  assign sid_s    = sync_q[SYNC_STAGES-1];
  assign tk       = enp & bit_tick;
  assign fall     = sid_prev_q & ~sid_s;
  assign stop_smp = (state_q == S_STOP) & tk & phase_q;

  // SID synchroniser and edge-detect history, idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      sid_prev_q <= 1'b1;
    end else if (enp) begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sid};
      sid_prev_q <= sid_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else if (enp) begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; only a true falling edge starts a frame, so a held-low break is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: if (tk) state_d = sid_s ? S_IDLE : S_DATA;
      S_DATA:  if (tk && phase_q && (bitcnt_q == LAST_BIT)) state_d = S_STOP;
      S_STOP:  if (tk && phase_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output / datapath next values; status flags give set priority over clears.
  always_comb begin
    phase_d   = phase_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    serin_d   = serin_q;
    rx_done_d = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          restart_d = 1'b1;
          phase_d   = 1'b0;
          bitcnt_d  = '0;
        end
      end
      S_START: begin
        if (tk && !sid_s) phase_d = 1'b0;
      end
      S_DATA: begin
        if (tk) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            shreg_d  = {sid_s, shreg_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tk) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            serin_d   = shreg_q;
            rx_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    rx_full_d   = stop_smp | (rx_full_q & ~host.irq_ack);
    frame_err_d = (stop_smp & ~sid_s) | (frame_err_q & ~host.err_clr);
    overrun_d   = (stop_smp & rx_full_q & ~host.irq_ack) | (overrun_q & ~host.err_clr);
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath and registered outputs, advanced only on enp cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      serin_q     <= '0;
      rx_done_q   <= 1'b0;
      rx_full_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      restart_q   <= 1'b0;
    end else if (enp) begin
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      serin_q     <= serin_d;
      rx_done_q   <= rx_done_d;
      rx_full_q   <= rx_full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      restart_q   <= restart_d;
    end
  end

  assign host.serin         = serin_q;
  assign host.rx_done       = rx_done_q;
  assign host.rx_full       = rx_full_q;
  assign host.frame_err     = frame_err_q;
  assign host.overrun_err   = overrun_q;
  assign host.busy          = busy_q;
  assign host.timer_restart = restart_q;

endmodule

// File: tb/tb_pokey_serin_rx.sv
// Self-checking bench for pokey_serin_rx: frames are driven per enp cycle with a timer
// model that issues half-bit ticks from the start edge; expected bytes go through a scoreboard.
module tb_pokey_serin_rx;

  localparam int unsigned DB = 8;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enp = 1'b0;
  logic bit_tick = 1'b0;
  logic sid = 1'b1;

  always #5 clk = ~clk;

  pokey_serin_rx_if #(.DATA_BITS(DB)) host ();

  pokey_serin_rx #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enp      (enp),
    .bit_tick (bit_tick),
    .sid      (sid),
    .host     (host.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int tr_cnt = 0;
  logic done_last = 1'b0;
  logic tr_last = 1'b0;

  // Monitor: counts pulses and checks every delivered byte against the scoreboard.
  always @(negedge clk) begin
    if (host.timer_restart && !tr_last) tr_cnt++;
    if (host.rx_done && !done_last) begin
      exp_t e;
      done_cnt++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_done_unexpected: serin=%h with empty scoreboard", host.serin);
      end else begin
        e = q.pop_front();
        if ({host.serin, host.frame_err, host.overrun_err, host.rx_full} !== {e.data, e.fe, e.ov, 1'b1}) begin
          n_fail++;
          $display("FAIL rx_byte: got serin=%h fe=%b ov=%b full=%b, want serin=%h fe=%b ov=%b full=1",
                   host.serin, host.frame_err, host.overrun_err, host.rx_full, e.data, e.fe, e.ov);
        end
      end
    end
    tr_last   = host.timer_restart;
    done_last = host.rx_done;
  end

  // One enp cycle, optionally preceded by gap clocks with enp low.
  task automatic cyc(input logic s, input logic t, input logic ack, input logic clr, input int gap);
    sid = s;
    bit_tick = t;
    host.irq_ack = ack;
    host.err_clr = clr;
    for (int g = 0; g < gap; g++) begin
      enp = 1'b0;
      @(posedge clk);
      #1;
    end
    enp = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) cyc(s, (i % H) == 0, 1'b0, 1'b0, 0);
  endtask

  // Drives one frame; ticks fall every h enp cycles starting h after the restart point.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int h, input int gap,
                            input bit tick_all, input bit ack_stop, input int ncyc);
    int total;
    int b;
    logic s;
    logic t;
    total = (ncyc > 0) ? ncyc : 20 * h + 2;
    for (int n = 0; n < total; n++) begin
      b = n / (2 * h);
      if (b == 0) s = 1'b0;
      else if (b <= 8) s = d[b-1];
      else s = stop;
      t = tick_all || (n >= h + 2 && ((n - 2) % h) == 0);
      cyc(s, t, logic'(ack_stop && (n == 2 + 19 * h)), 1'b0, gap);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
    if ({host.serin, host.rx_done, host.rx_full, host.frame_err, host.overrun_err, host.busy, host.timer_restart} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got serin=%h done=%b full=%b fe=%b ov=%b busy=%b tr=%b, want all 0",
               host.serin, host.rx_done, host.rx_full, host.frame_err, host.overrun_err, host.busy, host.timer_restart);
    end
    rst_n = 1'b1;
    idle(8, 1'b1);
  endtask

  task automatic test_basic_frame();
    int d0;
    int t0;
    d0 = done_cnt;
    t0 = tr_cnt;
    q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1, H, 0, 1'b0, 1'b0, 0);
    idle(4, 1'b1);
    chk("basic_serin", 32'(host.serin), 32'h A5);
    chk("basic_done_count", 32'(done_cnt - d0), 32'd1);
    chk("basic_restart_count", 32'(tr_cnt - t0), 32'd1);
    chk("basic_full_busy", {30'd0, host.rx_full, host.busy}, 32'b10);
    chk("basic_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic test_glitch();
    int d0;
    int t0;
    d0 = done_cnt;
    t0 = tr_cnt;
    for (int n = 0; n < 4 * H; n++)
      cyc(logic'(n >= H), logic'(n >= H + 2 && ((n - 2) % H) == 0), 1'b0, 1'b0, 0);
    chk("glitch_restart", 32'(tr_cnt - t0), 32'd1);
    chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    chk("glitch_state", {8'd0, host.serin, 12'd0, host.busy, host.frame_err, host.overrun_err, host.rx_full},
        {8'd0, 8'hA5, 12'd0, 4'b0001});
  endtask

  task automatic test_frame_err();
    int d0;
    int t0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("ack_clears_full", 32'(host.rx_full), 32'd0);
    q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, H, 0, 1'b0, 1'b0, 0);
    d0 = done_cnt;
    t0 = tr_cnt;
    idle(40 * H, 1'b0);
    chk("ferr_serin_flag", {23'd0, host.frame_err, host.serin}, {23'd0, 1'b1, 8'h3C});
    chk("break_no_frame", {16'(done_cnt - d0), 15'(tr_cnt - t0), host.busy}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("err_clr_frame", 32'(host.frame_err), 32'd0);
    idle(8, 1'b1);
    chk("ferr_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
    q.push_back('{8'h11, 1'b0, 1'b0});
    q.push_back('{8'h22, 1'b0, 1'b1});
    send_frame(8'h11, 1'b1, H, 0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, H, 0, 1'b0, 1'b0, 0);
    idle(4, 1'b1);
    chk("b2b_overrun", {23'd0, host.overrun_err, host.serin}, {23'd0, 1'b1, 8'h22});
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("b2b_cleared", {30'd0, host.overrun_err, host.rx_full}, 32'd0);
    q.push_back('{8'h11, 1'b0, 1'b0});
    q.push_back('{8'h22, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, H, 0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, H, 0, 1'b0, 1'b1, 0);
    idle(4, 1'b1);
    chk("b2b_ack_same_cycle", {30'd0, host.overrun_err, host.rx_full}, 32'b01);
    chk("b2b_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic test_reset_midframe();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, H, 0, 1'b0, 1'b0, 11 * H + H / 2);
    chk("mid_busy_before", 32'(host.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_now", {23'd0, host.busy, host.serin}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle(4, 1'b1);
    q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b1, H, 0, 1'b0, 1'b0, 0);
    idle(4, 1'b1);
    chk("mid_next_frame", 32'(host.serin), 32'h81);
    chk("mid_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic test_enp_gated();
    int d0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3);
    d0 = done_cnt;
    q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b1, 1, 3, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
    chk("gated_serin", 32'(host.serin), 32'h5A);
    chk("gated_done_count", 32'(done_cnt - d0), 32'd1);
    chk("gated_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    host.irq_ack = 1'b0;
    host.err_clr = 1'b0;
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_enp_gated();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
